// File: rtl/gameboy_lcd_generator_if.sv
// Display-side bundle of the DMG LCD generator: run request, frame-buffer read
// port and the regenerated panel signals.
interface gameboy_lcd_generator_if;
  logic        enable;
  logic [14:0] pixel_addr;
  logic [1:0]  pixel_data;
  logic        buffer_select;
  logic        frame_start;
  logic        pixel_clock;
  logic        h_sync;
  logic        v_sync;
  logic        lcd_data0;
  logic        lcd_data1;

  modport master (
    input  enable, pixel_data,
    output pixel_addr, buffer_select, frame_start,
           pixel_clock, h_sync, v_sync, lcd_data0, lcd_data1
  );

  modport slave (
    output enable, pixel_data,
    input  pixel_addr, buffer_select, frame_start,
           pixel_clock, h_sync, v_sync, lcd_data0, lcd_data1
  );
endinterface

// File: rtl/gameboy_lcd_generator.sv
// DMG-style LCD timing generator reading a 2bpp frame buffer.
// Define GB_LCD_GATE_PCLK_EN to stop pixel_clock in horizontal blank (sync period still pulses).
module gameboy_lcd_generator #(
  parameter int H_ACTIVE = 160,
  parameter int V_ACTIVE = 144,
  parameter int H_TOTAL  = 200,
  parameter int V_TOTAL  = 154,
  parameter int CLK_DIV  = 3
) (
  input logic                       clock,
  input logic                       reset,
  gameboy_lcd_generator_if.master   lcd
);

  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT     = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT     = VW'(V_ACTIVE);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [14:0]   ADDR_LAST = 15'(H_ACTIVE * V_ACTIVE - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e        state_q;
  logic [DW-1:0] div_q;
  logic          phase_q;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [14:0]   addr_q;
  logic          buf_q, frame_q, pclk_q, hs_q, vs_q;
  logic [1:0]    data_q;

  logic div_wrap, launch, h_wrap, v_wrap, active, pclk_gate;

  // h_q/v_q hold the position that the NEXT launch edge will present.
  // NOTE: every combinational output gets a default first, so no latch is inferred.
  always_comb begin
    div_wrap = (div_q == DIV_LAST);
    launch   = (state_q == RUN) && div_wrap && !phase_q;
    h_wrap   = (h_q == H_LAST);
    v_wrap   = (v_q == V_LAST);
    active   = (h_q < H_ACT) && (v_q < V_ACT);
    h_d      = h_wrap ? '0 : h_q + 1'b1;
    v_d      = v_q;
    if (h_wrap) v_d = v_wrap ? '0 : v_q + 1'b1;
  end

`ifdef GB_LCD_GATE_PCLK_EN
  assign pclk_gate = (h_q >= H_ACT) && !h_wrap;
`else
  assign pclk_gate = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every register sees
  // the pre-edge values; later assignments in the block override earlier ones.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      phase_q <= 1'b0;
      h_q     <= H_LAST;
      v_q     <= V_LAST;
      addr_q  <= '0;
      buf_q   <= 1'b0;
      frame_q <= 1'b0;
      pclk_q  <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      data_q  <= 2'b00;
    end else begin
      frame_q <= 1'b0;
      case (state_q)
        IDLE: begin
          div_q   <= '0;
          phase_q <= 1'b0;
          pclk_q  <= 1'b0;
          hs_q    <= 1'b0;
          vs_q    <= 1'b0;
          data_q  <= 2'b00;
          if (lcd.enable) state_q <= RUN;
        end
        RUN: begin
          div_q <= div_wrap ? '0 : div_q + 1'b1;
          if (div_wrap) phase_q <= !phase_q;
          if (div_wrap && phase_q) pclk_q <= 1'b0;
          if (launch) begin
            if (h_wrap && v_wrap && !lcd.enable) begin
              // Stop on the frame boundary; counters stay parked on the sync period.
              state_q <= IDLE;
              div_q   <= '0;
              phase_q <= 1'b0;
              pclk_q  <= 1'b0;
              hs_q    <= 1'b0;
              vs_q    <= 1'b0;
              data_q  <= 2'b00;
            end else begin
              pclk_q <= !pclk_gate;
              hs_q   <= h_wrap;
              vs_q   <= v_wrap;
              data_q <= active ? lcd.pixel_data : 2'b00;
              h_q    <= h_d;
              v_q    <= v_d;
              if (active) begin
                addr_q <= (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
                if (h_q == '0 && v_q == '0) begin
                  buf_q   <= !buf_q;
                  frame_q <= 1'b1;
                end
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lcd.pixel_addr    = addr_q;
  assign lcd.buffer_select = buf_q;
  assign lcd.frame_start   = frame_q;
  assign lcd.pixel_clock   = pclk_q;
  assign lcd.h_sync        = hs_q;
  assign lcd.v_sync        = vs_q;
  assign lcd.lcd_data0     = data_q[0];
  assign lcd.lcd_data1     = data_q[1];

endmodule
